// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler:
// timer register map, control bits and FSM states.
package timer_sched_pkg;

    localparam logic [1:0] TMR_CNT  = 2'd0;
    localparam logic [1:0] TMR_CTRL = 2'd2;
    localparam logic [1:0] TMR_PER  = 2'd3;

    localparam int CTRL_EN_BIT = 7;

    typedef enum logic [3:0] {
        IDLE,
        GRANT,
        WR_PER,
        WR_CNT,
        WR_EN,
        WAIT,
        STOP,
        DONE,
        ABORT
    } state_t;

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted
// request at or above ptr, wrapping around.
module timer_sched_rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IW-1:0]   gnt_idx,
    output logic            vld
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int j;
        logic [IW-1:0] j_idx;
        j       = 0;
        j_idx   = '0;
        gnt_oh  = '0;
        gnt_idx = '0;
        vld     = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            j_idx = IW'(j);
            if (req[j_idx]) begin
                gnt_oh        = '0;
                gnt_oh[j_idx] = 1'b1;
                gnt_idx       = j_idx;
                vld           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_sched.sv
// Round-robin scheduler of one-shot delays on the
// shared timer; all outputs are registered.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*CW-1:0] req_delay,
    input  logic             abort,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             aborted,
    output logic             busy,
    output logic             tmr_wr_en,
    output logic [1:0]       tmr_wr_addr,
    output logic [CW-1:0]    tmr_wr_data,
    input  logic             tmr_match
);

    localparam int IW = $clog2(NREQ);

    state_t state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   delay_q, delay_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            busy_q, busy_d;
    logic            wr_en_q, wr_en_d;
    logic [1:0]      wr_addr_q, wr_addr_d;
    logic [CW-1:0]   wr_data_q, wr_data_d;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [CW-1:0]   pick_delay;

    timer_sched_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .vld     (pick_vld)
    );

    // Select the delay slice of the requester being picked.
    always_comb begin
        pick_delay = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) pick_delay = req_delay[i*CW +: CW];
        end
    end

    // Next state plus the registered outputs of the current state.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        delay_d   = delay_q;
        gnt_d     = '0;
        done_d    = '0;
        aborted_d = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        unique case (state_q)
            IDLE: begin
                if (|req) state_d = GRANT;
            end
            GRANT: begin
                if (pick_vld) begin
                    gnt_d   = pick_oh;
                    owner_d = pick_idx;
                    delay_d = pick_delay;
                    if (pick_idx == IW'(NREQ - 1)) ptr_d = '0;
                    else ptr_d = pick_idx + IW'(1);
                    state_d = (pick_delay == '0) ? DONE : WR_PER;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_PER: begin
                wr_en_d   = 1'b1;
                wr_addr_d = TMR_PER;
                wr_data_d = delay_q;
                state_d   = abort ? ABORT : WR_CNT;
            end
            WR_CNT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = TMR_CNT;
                wr_data_d = '0;
                state_d   = abort ? ABORT : WR_EN;
            end
            WR_EN: begin
                wr_en_d   = 1'b1;
                wr_addr_d = TMR_CTRL;
                wr_data_d = CW'(1 << CTRL_EN_BIT);
                state_d   = abort ? ABORT : WAIT;
            end
            WAIT: begin
                if (abort) state_d = ABORT;
                else if (tmr_match) state_d = STOP;
            end
            STOP: begin
                wr_en_d   = 1'b1;
                wr_addr_d = TMR_CTRL;
                wr_data_d = '0;
                state_d   = DONE;
            end
            DONE: begin
                done_d[owner_q] = 1'b1;
                state_d         = IDLE;
            end
            ABORT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = TMR_CTRL;
                wr_data_d = '0;
                aborted_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, arbitration context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            delay_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            delay_q   <= delay_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign busy        = busy_q;
    assign tmr_wr_en   = wr_en_q;
    assign tmr_wr_addr = wr_addr_q;
    assign tmr_wr_data = wr_data_q;

endmodule
